// File: rtl/stream_receiver.sv
// Receiving end of the counter stream: buffers strobed words in a FIFO, throttles the source
// and flags words that do not follow their predecessor by exactly one.
module stream_receiver #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       src_en,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       seq_err,
  output logic [7:0]                 err_cnt,
  output logic                       ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [0:0] {StUnarmed, StArmed} chk_state_e;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             rd_valid_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             ovf_q;
  logic             full, do_wr, do_rd, drop;

  chk_state_e       state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             seq_err_q, seq_err_d;
  logic [7:0]       err_cnt_q;

  always_comb begin
    full  = (level_q == LW'(DEPTH));
    do_rd = rd_en && (level_q != '0);
    // A full FIFO still accepts a word when the same cycle frees a slot.
    do_wr = in_valid && (!full || do_rd);
    drop  = in_valid && full && !rd_en;
    // Keep one slot spare for the word already in flight from the registered source.
    src_en = !rst && (level_q <= LW'(DEPTH - 2));
  end

  always_comb begin
    level_d = level_q;
    unique case ({do_wr, do_rd})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      level_q    <= level_d;
      rd_valid_q <= do_rd;
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        rd_data_q <= mem[rd_ptr_q];
      end
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Every strobed word, stored or dropped, feeds the checker and reloads the expectation.
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    seq_err_d = 1'b0;
    if (in_valid) begin
      exp_d   = in_data + WIDTH'(1);
      state_d = StArmed;
      if (state_q == StArmed && in_data != exp_q) seq_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StUnarmed;
      exp_q     <= '0;
      seq_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      seq_err_q <= seq_err_d;
      if (seq_err_d && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign level    = level_q;
  assign seq_err  = seq_err_q;
  assign err_cnt  = err_cnt_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_stream_receiver.sv
// Directed bench for stream_receiver: a vector table for streaming and back-pressure, plus
// hand-written sequences for overflow, sequence errors, wrap-around and reset corner cases.
module tb_stream_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        src_en;
  logic        rd_en;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [2:0]  level;
  logic        seq_err;
  logic [7:0]  err_cnt;
  logic        ovf;

  int checks = 0;
  int fails  = 0;

  stream_receiver #(.DEPTH(4), .WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .src_en   (src_en),
    .rd_en    (rd_en),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .level    (level),
    .seq_err  (seq_err),
    .err_cnt  (err_cnt),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic        rd;
    logic        rv;
    logic [15:0] rdata;
    logic [2:0]  lvl;
    logic        src;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then settle away from the edge.
  task automatic tick(input logic iv, input logic [15:0] d, input logic rd);
    in_valid = iv;
    in_data  = d;
    rd_en    = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = '0;
    rd_en    = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 16'd0, 1'b1, 1'b0, 16'd0, 3'd1, 1'b1};
    tbl[1]  = '{1'b1, 16'd1, 1'b1, 1'b1, 16'd0, 3'd1, 1'b1};
    tbl[2]  = '{1'b1, 16'd2, 1'b1, 1'b1, 16'd1, 3'd1, 1'b1};
    tbl[3]  = '{1'b1, 16'd3, 1'b1, 1'b1, 16'd2, 3'd1, 1'b1};
    tbl[4]  = '{1'b0, 16'd0, 1'b1, 1'b1, 16'd3, 3'd0, 1'b1};
    tbl[5]  = '{1'b0, 16'd0, 1'b1, 1'b0, 16'd3, 3'd0, 1'b1};
    tbl[6]  = '{1'b1, 16'd4, 1'b0, 1'b0, 16'd3, 3'd1, 1'b1};
    tbl[7]  = '{1'b1, 16'd5, 1'b0, 1'b0, 16'd3, 3'd2, 1'b1};
    tbl[8]  = '{1'b1, 16'd6, 1'b0, 1'b0, 16'd3, 3'd3, 1'b0};
    tbl[9]  = '{1'b1, 16'd7, 1'b0, 1'b0, 16'd3, 3'd4, 1'b0};
    tbl[10] = '{1'b0, 16'd0, 1'b0, 1'b0, 16'd3, 3'd4, 1'b0};
    tbl[11] = '{1'b0, 16'd0, 1'b1, 1'b1, 16'd4, 3'd3, 1'b0};
    tbl[12] = '{1'b0, 16'd0, 1'b1, 1'b1, 16'd5, 3'd2, 1'b1};
    tbl[13] = '{1'b0, 16'd0, 1'b1, 1'b1, 16'd6, 3'd1, 1'b1};
    tbl[14] = '{1'b0, 16'd0, 1'b1, 1'b1, 16'd7, 3'd0, 1'b1};

    in_valid = 1'b0;
    in_data  = '0;
    rd_en    = 1'b0;
    rst      = 1'b1;
    #12;
    chk("reset src_en", 32'(src_en), 32'd0);
    chk("reset level", 32'(level), 32'd0);
    chk("reset rd_valid", 32'(rd_valid), 32'd0);
    chk("reset rd_data", 32'(rd_data), 32'd0);
    chk("reset seq_err", 32'(seq_err), 32'd0);
    chk("reset err_cnt", 32'(err_cnt), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("src_en after reset", 32'(src_en), 32'd1);

    // Streaming with rd_en held, then back-pressure and drain.
    for (int i = 0; i < 15; i++) begin
      tick(tbl[i].iv, tbl[i].d, tbl[i].rd);
      chk($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(tbl[i].rv));
      chk($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(tbl[i].rdata));
      chk($sformatf("vec%0d level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("vec%0d src_en", i), 32'(src_en), 32'(tbl[i].src));
      chk($sformatf("vec%0d seq_err", i), 32'(seq_err), 32'd0);
      chk($sformatf("vec%0d ovf", i), 32'(ovf), 32'd0);
    end
    chk("table err_cnt", 32'(err_cnt), 32'd0);

    // Forced overflow: dropped word 7 also mismatches the expected 4.
    do_reset();
    for (int i = 0; i < 4; i++) tick(1'b1, 16'(i), 1'b0);
    chk("ovf pre level", 32'(level), 32'd4);
    chk("ovf pre flag", 32'(ovf), 32'd0);
    tick(1'b1, 16'd7, 1'b0);
    chk("ovf flag", 32'(ovf), 32'd1);
    chk("ovf level", 32'(level), 32'd4);
    chk("ovf drop seq_err", 32'(seq_err), 32'd1);
    tick(1'b0, 16'd0, 1'b1);
    chk("ovf head rd_valid", 32'(rd_valid), 32'd1);
    chk("ovf head rd_data", 32'(rd_data), 32'd0);
    chk("ovf sticky", 32'(ovf), 32'd1);
    chk("ovf level after read", 32'(level), 32'd3);

    // Sequence 5,6,9,10: single error pulse after the 9.
    do_reset();
    tick(1'b1, 16'd5, 1'b1);
    chk("seq 5", 32'(seq_err), 32'd0);
    tick(1'b1, 16'd6, 1'b1);
    chk("seq 6", 32'(seq_err), 32'd0);
    tick(1'b1, 16'd9, 1'b1);
    chk("seq 9 pulse", 32'(seq_err), 32'd1);
    chk("seq 9 count", 32'(err_cnt), 32'd1);
    tick(1'b1, 16'd10, 1'b1);
    chk("seq 10", 32'(seq_err), 32'd0);
    chk("seq 10 count", 32'(err_cnt), 32'd1);

    // 300 further mismatches saturate the counter.
    for (int i = 0; i < 300; i++) tick(1'b1, 16'd0, 1'b1);
    chk("sat seq_err", 32'(seq_err), 32'd1);
    chk("sat err_cnt", 32'(err_cnt), 32'd255);
    tick(1'b0, 16'd0, 1'b1);
    chk("sat pulse ends", 32'(seq_err), 32'd0);

    // Modular wrap of the expectation, then pointers wrapping with in-order data.
    do_reset();
    tick(1'b1, 16'hFFFE, 1'b1);
    tick(1'b1, 16'hFFFF, 1'b1);
    chk("wrap FFFF", 32'(seq_err), 32'd0);
    tick(1'b1, 16'h0000, 1'b1);
    chk("wrap 0000", 32'(seq_err), 32'd0);
    chk("wrap rd_data", 32'(rd_data), 32'hFFFF);
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1, 16'(i), 1'b1);
      chk($sformatf("wrap pair%0d rd_valid", i), 32'(rd_valid), 32'd1);
      chk($sformatf("wrap pair%0d rd_data", i), 32'(rd_data), 32'(i - 1));
      chk($sformatf("wrap pair%0d level", i), 32'(level), 32'd1);
    end
    chk("wrap err_cnt", 32'(err_cnt), 32'd0);

    // Empty with simultaneous write and read: no bypass.
    do_reset();
    tick(1'b1, 16'h0042, 1'b1);
    chk("empty rd_valid", 32'(rd_valid), 32'd0);
    chk("empty rd_data held", 32'(rd_data), 32'd0);
    chk("empty level", 32'(level), 32'd1);
    tick(1'b0, 16'd0, 1'b1);
    chk("empty next rd_valid", 32'(rd_valid), 32'd1);
    chk("empty next rd_data", 32'(rd_data), 32'h0042);

    // Asynchronous reset mid-operation disarms the checker.
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 16'(16'h0100 + i), 1'b0);
    tick(1'b0, 16'd0, 1'b1);
    chk("pre-rst level", 32'(level), 32'd2);
    chk("pre-rst rd_valid", 32'(rd_valid), 32'd1);
    tick(1'b1, 16'h0103, 1'b0);
    chk("pre-rst level3", 32'(level), 32'd3);
    rd_en    = 1'b0;
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async rst level", 32'(level), 32'd0);
    chk("async rst rd_valid", 32'(rd_valid), 32'd0);
    chk("async rst src_en", 32'(src_en), 32'd0);
    #1;
    rst = 1'b0;
    tick(1'b1, 16'h1234, 1'b0);
    chk("rearm seq_err", 32'(seq_err), 32'd0);
    chk("rearm level", 32'(level), 32'd1);
    tick(1'b1, 16'h1235, 1'b0);
    chk("rearm follow", 32'(seq_err), 32'd0);
    tick(1'b1, 16'h0000, 1'b0);
    chk("rearm armed", 32'(seq_err), 32'd1);
    chk("rearm err_cnt", 32'(err_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
